// File: rtl/hazard_pkg.sv
// Shared types and encodings for the F/D/E/M/W hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_REG      = 2'b00;
    localparam logic [1:0] FWD_W        = 2'b01;
    localparam logic [1:0] FWD_M        = 2'b10;
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    // Register-index width carried in the tracking struct.
    localparam int TRK_AW = 5;

    typedef struct packed {
        logic              reg_write;
        logic              is_load;
        logic [TRK_AW-1:0] rd;
        logic [TRK_AW-1:0] rs1;
        logic [TRK_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } stage_trk_t;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic rd_match(input logic wr, input logic [TRK_AW-1:0] rd,
                                      input logic [TRK_AW-1:0] rs, input logic use_rs);
        return wr && (rd != '0) && (rd == rs) && use_rs;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Define HAZARD_FWD_EN for forwarding mode; otherwise stall-only.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = TRK_AW,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic                      use_rs1_d,
    input  logic                      use_rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      reg_write_d,
    input  logic                      is_load_d,
    input  logic                      pc_src_e,
    input  logic                      mem_wait,
    input  logic                      cnt_clr,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_em,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic [1:0]                fwd_a_e,
    output logic [1:0]                fwd_b_e,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    stage_trk_t trk_d, trk_e, trk_m, trk_w;
    logic       hit_e, hit_m, hazard;
    logic       stall_inc, flush_inc;

    assign trk_d = '{reg_write: reg_write_d, is_load: is_load_d, rd: rd_d,
                     rs1: rs1_d, rs2: rs2_d, use_rs1: use_rs1_d, use_rs2: use_rs2_d};

    // A frozen memory stage freezes every tracked stage, including E.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trk_e <= '0;
            trk_m <= '0;
            trk_w <= '0;
        end else if (!mem_wait) begin
            trk_e <= flush_e ? '0 : trk_d;
            trk_m <= trk_e;
            trk_w <= trk_m;
        end
    end

    assign hit_e = rd_match(trk_e.reg_write, trk_e.rd, rs1_d, use_rs1_d) ||
                   rd_match(trk_e.reg_write, trk_e.rd, rs2_d, use_rs2_d);
    assign hit_m = rd_match(trk_m.reg_write, trk_m.rd, rs1_d, use_rs1_d) ||
                   rd_match(trk_m.reg_write, trk_m.rd, rs2_d, use_rs2_d);

`ifdef HAZARD_FWD_EN
    assign hazard = trk_e.is_load && hit_e;

    always_comb begin
        fwd_a_e = FWD_REG;
        fwd_b_e = FWD_REG;
        if (rd_match(trk_m.reg_write, trk_m.rd, trk_e.rs1, trk_e.use_rs1))
            fwd_a_e = FWD_M;
        else if (rd_match(trk_w.reg_write, trk_w.rd, trk_e.rs1, trk_e.use_rs1))
            fwd_a_e = FWD_W;
        if (rd_match(trk_m.reg_write, trk_m.rd, trk_e.rs2, trk_e.use_rs2))
            fwd_b_e = FWD_M;
        else if (rd_match(trk_w.reg_write, trk_w.rd, trk_e.rs2, trk_e.use_rs2))
            fwd_b_e = FWD_W;
    end
`else
    // Regfile write-first covers a W-stage producer, so only E and M stall.
    assign hazard  = hit_e || hit_m;
    assign fwd_a_e = FWD_REG;
    assign fwd_b_e = FWD_REG;
`endif

    // Not every tracked field feeds logic in both build modes.
    logic unused_trk;
    assign unused_trk = ^{trk_e, trk_m, trk_w};

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (mem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign stall_inc = !mem_wait && !pc_src_e && hazard;
    assign flush_inc = !mem_wait && pc_src_e;

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(stall_inc), .q(stall_cnt)
    );

    sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
        .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(flush_inc), .q(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rs1_d, rs2_d, rd_d;
    logic          use_rs1_d, use_rs2_d, reg_write_d, is_load_d;
    logic          pc_src_e, mem_wait, cnt_clr;
    logic          stall_f, stall_d, stall_em, flush_d, flush_e;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d), .is_load_d(is_load_d),
        .pc_src_e(pc_src_e), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
        .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string t, input logic sf, input logic sd, input logic sem,
                       input logic fd, input logic fe);
        chk({t, ".stall_f"},  32'(stall_f),  32'(sf));
        chk({t, ".stall_d"},  32'(stall_d),  32'(sd));
        chk({t, ".stall_em"}, 32'(stall_em), 32'(sem));
        chk({t, ".flush_d"},  32'(flush_d),  32'(fd));
        chk({t, ".flush_e"},  32'(flush_e),  32'(fe));
    endtask

    task automatic drv(input logic [AW-1:0] r1, input logic u1, input logic [AW-1:0] r2,
                       input logic u2, input logic [AW-1:0] rd, input logic wr, input logic ld);
        rs1_d = r1; use_rs1_d = u1; rs2_d = r2; use_rs2_d = u2;
        rd_d = rd; reg_write_d = wr; is_load_d = ld;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0; pc_src_e = 1'b0; mem_wait = 1'b0; cnt_clr = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        ctl("reset", 0, 0, 0, 0, 0);
        chk("reset.fwd_a", 32'(fwd_a_e), 0);
        chk("reset.fwd_b", 32'(fwd_b_e), 0);
        chk("reset.stall_cnt", 32'(stall_cnt), 0);
        chk("reset.flush_cnt", 32'(flush_cnt), 0);

        // 1: lw x5 in E, add reads x5 in D
        drv(0, 0, 0, 0, 5, 1, 1); tick();
        drv(5, 1, 0, 0, 6, 1, 0); #1;
        ctl("t1.c0", 1, 1, 0, 0, 1);
        tick();
        ctl("t1.c1", !FWD, !FWD, 0, 0, !FWD);
        tick();
        chk("t1.c2.stall_d", 32'(stall_d), 0);
        chk("t1.c2.fwd_a", 32'(fwd_a_e), FWD ? 32'h1 : 32'h0);
        exp_stall = FWD ? 1 : 2;
        chk("t1.stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        idle(3);

        // 2: x3 written by the two previous ALU ops, then read
        drv(0, 0, 0, 0, 3, 1, 0); tick();
        drv(0, 0, 0, 0, 3, 1, 0); tick();
        drv(3, 1, 0, 1, 7, 1, 0); #1;
        chk("t2.c0.stall_d", 32'(stall_d), 32'(!FWD));
        tick();
        chk("t2.c1.stall_d", 32'(stall_d), 32'(!FWD));
        chk("t2.c1.fwd_a", 32'(fwd_a_e), FWD ? 32'h2 : 32'h0);
        chk("t2.c1.fwd_b", 32'(fwd_b_e), 0);
        tick();
        chk("t2.c2.stall_d", 32'(stall_d), 0);
        exp_stall += FWD ? 0 : 2;
        chk("t2.stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        idle(3);

        // 3: redirect beats a same-cycle load-use
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("t3.clr.stall_cnt", 32'(stall_cnt), 0);
        drv(0, 0, 0, 0, 5, 1, 1); tick();
        drv(5, 1, 0, 0, 6, 1, 0); pc_src_e = 1'b1; #1;
        ctl("t3", 0, 0, 0, 1, 1);
        tick();
        pc_src_e = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0); #1;
        chk("t3.flush_cnt", 32'(flush_cnt), 1);
        chk("t3.stall_cnt", 32'(stall_cnt), 0);
        idle(3);

        // 4: memory wait during load-use; redirect is held off too
        drv(0, 0, 0, 0, 5, 1, 1); tick();
        drv(5, 1, 0, 0, 6, 1, 0); mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_src_e = (i == 2); #1;
            ctl("t4.wait", 1, 1, 1, 0, 0);
            tick();
        end
        mem_wait = 1'b0; pc_src_e = 1'b0; #1;
        ctl("t4.after", 1, 1, 0, 0, 1);
        chk("t4.stall_cnt", 32'(stall_cnt), 0);
        chk("t4.flush_cnt", 32'(flush_cnt), 1);
        tick();
        chk("t4.stall_cnt_inc", 32'(stall_cnt), 1);
        idle(3);

        // 5: saturation, then clear beating an increment
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drv(0, 0, 0, 0, 5, 1, 1); tick();
            drv(5, 1, 0, 0, 6, 1, 0); tick();
        end
        chk("t5.sat", 32'(stall_cnt), 32'hF);
        drv(0, 0, 0, 0, 5, 1, 1); tick();
        drv(5, 1, 0, 0, 6, 1, 0); cnt_clr = 1'b1; #1;
        chk("t5.clr.stall_d", 32'(stall_d), 1);
        tick();
        cnt_clr = 1'b0;
        chk("t5.clr", 32'(stall_cnt), 0);
        idle(3);

        // 6: reset during a stall, then an x0 writer
        drv(0, 0, 0, 0, 5, 1, 1); tick();
        drv(5, 1, 0, 0, 6, 1, 0); #1;
        chk("t6.pre.stall_d", 32'(stall_d), 1);
        reset_n = 1'b0; tick();
        reset_n = 1'b1; drv(5, 1, 0, 0, 6, 1, 0); #1;
        ctl("t6.rst", 0, 0, 0, 0, 0);
        chk("t6.rst.flush_cnt", 32'(flush_cnt), 0);
        chk("t6.rst.stall_cnt", 32'(stall_cnt), 0);
        drv(0, 0, 0, 0, 0, 1, 1); tick();
        drv(0, 1, 0, 1, 8, 1, 0); #1;
        chk("t6.x0.stall_d", 32'(stall_d), 0);
        tick();
        chk("t6.x0.fwd_a_m", 32'(fwd_a_e), 0);
        chk("t6.x0.fwd_b_m", 32'(fwd_b_e), 0);
        tick();
        chk("t6.x0.fwd_a_w", 32'(fwd_a_e), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
